// File: rtl/galois_lfsr_gen_if.sv
// Generator-side bundle for the Galois LFSR: control strobes in, word/valid/state out.
interface galois_lfsr_gen_if #(
  parameter int LFSR_WIDTH                 = 8,
  parameter int LFSR_OUTPUT_BITS_PER_CLOCK = 8
);
  logic                                  init;
  logic                                  enable;
  logic [LFSR_OUTPUT_BITS_PER_CLOCK-1:0] out;
  logic                                  valid;
  logic [LFSR_WIDTH-1:0]                 state;

  modport master (
    input  init,
    input  enable,
    output out,
    output valid,
    output state
  );

  modport slave (
    output init,
    output enable,
    input  out,
    input  valid,
    input  state
  );
endinterface

// File: rtl/galois_lfsr_gen.sv
// Galois LFSR producing LFSR_OUTPUT_BITS_PER_CLOCK bits per enabled clock, earliest bit in the MSB.
// Single-cycle: results register on the enabled edge; valid is a per-cycle qualifier with no backpressure.
module galois_lfsr_gen #(
  parameter int                    LFSR_WIDTH                 = 8,
  parameter int                    LFSR_OUTPUT_BITS_PER_CLOCK = 8,
  parameter logic [LFSR_WIDTH-1:0] LFSR_TAPS                  = 8'hB8,
  parameter logic [LFSR_WIDTH-1:0] LFSR_SEED                  = {{(LFSR_WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic              clk,
  input  logic              reset,
  galois_lfsr_gen_if.master lfsr
);

  logic [LFSR_WIDTH-1:0]                 state_q;
  logic [LFSR_OUTPUT_BITS_PER_CLOCK-1:0] out_q;
  logic                                  valid_q;

  logic [LFSR_WIDTH-1:0]                 step_state;
  logic [LFSR_OUTPUT_BITS_PER_CLOCK-1:0] step_out;

  // Fully unrolled K single steps; the bit leaving s[0] at step i lands in out[K-1-i].
  always_comb begin
    step_state = state_q;
    step_out   = '0;
    for (int i = 0; i < LFSR_OUTPUT_BITS_PER_CLOCK; i++) begin
      step_out[LFSR_OUTPUT_BITS_PER_CLOCK-1-i] = step_state[0];
      step_state = (step_state >> 1) ^ (step_state[0] ? LFSR_TAPS : '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LFSR_SEED;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else if (lfsr.init) begin
      state_q <= LFSR_SEED;
      valid_q <= 1'b0;
    end else if (lfsr.enable) begin
      valid_q <= 1'b1;
      // All-zero state would stick forever; recover by reloading the seed.
      if (state_q == '0) begin
        state_q <= LFSR_SEED;
        out_q   <= '0;
      end else begin
        state_q <= step_state;
        out_q   <= step_out;
      end
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign lfsr.state = state_q;
  assign lfsr.out   = out_q;
  assign lfsr.valid = valid_q;

endmodule

// File: tb/tb_galois_lfsr_gen.sv
// Bench for galois_lfsr_gen at default parameters: vector table plus scoreboard of expected words.
module tb_galois_lfsr_gen;

  localparam int         W    = 8;
  localparam int         K    = 8;
  localparam logic [7:0] TAPS = 8'hB8;
  localparam logic [7:0] SEED = 8'h01;

  typedef struct {
    logic       init;
    logic       enable;
    logic [7:0] exp_out;
    logic [7:0] exp_state;
    logic       exp_valid;
  } vec_t;

  typedef struct {
    logic [7:0] out;
    logic [7:0] state;
  } word_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  galois_lfsr_gen_if #(.LFSR_WIDTH(W), .LFSR_OUTPUT_BITS_PER_CLOCK(K)) bus ();

  galois_lfsr_gen #(
    .LFSR_WIDTH                 (W),
    .LFSR_OUTPUT_BITS_PER_CLOCK (K),
    .LFSR_TAPS                  (TAPS),
    .LFSR_SEED                  (SEED)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .lfsr  (bus)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  word_t sb_q[$];
  logic  exp_vld = 1'b0;
  logic  [7:0] mdl_state = SEED;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic word_t mdl_step(input logic [7:0] s);
    word_t r;
    r.out = '0;
    if (s == '0) begin
      r.state = SEED;
    end else begin
      for (int i = 0; i < K; i++) begin
        r.out[K-1-i] = s[0];
        s = (s >> 1) ^ (s[0] ? TAPS : 8'h00);
      end
      r.state = s;
    end
    return r;
  endfunction

  // Drive inputs for the next edge and record what the model predicts for it.
  task automatic drive(input logic i, input logic e);
    word_t w;
    bus.init   = i;
    bus.enable = e;
    exp_vld    = e && !i;
    if (i) begin
      mdl_state = SEED;
    end else if (e) begin
      w = mdl_step(mdl_state);
      mdl_state = w.state;
      sb_q.push_back(w);
    end
  endtask

  // Advance one edge and retire the scoreboard against the DUT output.
  task automatic tick();
    word_t w;
    @(posedge clk);
    #1;
    check("sb_valid", {31'b0, bus.valid}, {31'b0, exp_vld});
    if (bus.valid) begin
      if (sb_q.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL sb_empty: valid with no expected word, out %0h", bus.out);
      end else begin
        w = sb_q.pop_front();
        check("sb_out", {24'b0, bus.out}, {24'b0, w.out});
        check("sb_state", {24'b0, bus.state}, {24'b0, w.state});
      end
    end else if (sb_q.size() != 0) begin
      void'(sb_q.pop_front());
    end
  endtask

  task automatic model_reset();
    sb_q.delete();
    exp_vld   = 1'b0;
    mdl_state = SEED;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[10];
    logic [255:0] seen;
    int distinct;
    int early;

    vecs[0] = '{1'b0, 1'b0, 8'h00, 8'h01, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 8'h8E, 8'h64, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 8'h25, 8'h93, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 8'h25, 8'h93, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 8'h25, 8'h93, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 8'h25, 8'h93, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 8'hC0, 8'h03, 1'b1};
    vecs[7] = '{1'b1, 1'b1, 8'hC0, 8'h01, 1'b0};
    vecs[8] = '{1'b0, 1'b1, 8'h8E, 8'h64, 1'b1};
    vecs[9] = '{1'b1, 1'b0, 8'h8E, 8'h01, 1'b0};

    bus.init   = 1'b0;
    bus.enable = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", {24'b0, bus.state}, 32'h01);
    check("rst_out", {24'b0, bus.out}, 32'h00);
    check("rst_valid", {31'b0, bus.valid}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Idle after reset: nothing moves.
    for (int c = 0; c < 10; c++) begin
      drive(1'b0, 1'b0);
      tick();
      check("idle_state", {24'b0, bus.state}, 32'h01);
      check("idle_out", {24'b0, bus.out}, 32'h00);
    end

    // Vector table: first words, enable gap, init with enable, init alone.
    for (int v = 0; v < 10; v++) begin
      drive(vecs[v].init, vecs[v].enable);
      tick();
      check($sformatf("vec%0d_out", v), {24'b0, bus.out}, {24'b0, vecs[v].exp_out});
      check($sformatf("vec%0d_state", v), {24'b0, bus.state}, {24'b0, vecs[v].exp_state});
      check($sformatf("vec%0d_valid", v), {31'b0, bus.valid}, {31'b0, vecs[v].exp_valid});
    end

    // Full period from the seed: back to 8'h01 exactly at word 255.
    seen     = '0;
    distinct = 0;
    early    = 0;
    for (int c = 1; c <= 255; c++) begin
      drive(1'b0, 1'b1);
      tick();
      if (!seen[bus.state] && bus.state != 8'h00) distinct++;
      seen[bus.state] = 1'b1;
      if (c < 255 && bus.state == 8'h01) early++;
    end
    check("period_final_state", {24'b0, bus.state}, 32'h01);
    check("period_early_return", early, 0);
    check("period_distinct", distinct, 255);

    // init mid-run after 5 words, together with enable.
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, 1'b1);
      tick();
    end
    drive(1'b1, 1'b1);
    tick();
    check("init_state", {24'b0, bus.state}, 32'h01);
    check("init_valid", {31'b0, bus.valid}, 32'h0);
    drive(1'b0, 1'b1);
    tick();
    check("init_restart_out", {24'b0, bus.out}, 32'h8E);
    check("init_restart_state", {24'b0, bus.state}, 32'h64);

    // Asynchronous reset between edges while running.
    drive(1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b1);
    #3;
    reset = 1'b1;
    #1;
    check("arst_state", {24'b0, bus.state}, 32'h01);
    check("arst_out", {24'b0, bus.out}, 32'h00);
    check("arst_valid", {31'b0, bus.valid}, 32'h0);
    bus.enable = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 1'b1);
    tick();
    check("arst_restart_out", {24'b0, bus.out}, 32'h8E);
    check("arst_restart_state", {24'b0, bus.state}, 32'h64);
    drive(1'b0, 1'b1);
    tick();
    check("arst_second_out", {24'b0, bus.out}, 32'h25);
    drive(1'b0, 1'b0);
    tick();

    check("sb_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
